voice_mix_sched: RTL
====================

Name: voice_mix_sched

Overview:
- Time-multiplexed mixer controller for the 16-voice FM synth output.
- Replaces the parallel 16-input adder tree with one shared accumulator.
- On each audio sample tick, it reads the 16 voice samples one at a time from the voice store (fixed read latency), adds only the enabled voices, and presents one Q6.18 mixed sample with a valid pulse.
- Sits between the voice generator sample store and the output DAC/filter stage.

Parameters:
- NUM_BITS_IN, 18, voice sample width, signed Q2.16.
- NUM_BITS_OUT, 24, mixed output width, signed Q6.18.
- RD_LAT, 1, cycles from voice_rd to voice_data valid; legal range 1–4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sample_tick  in  1  one-cycle pulse that starts a mix pass
- voice_en  in  16  per-voice enable, sampled on the accepted tick
- voice_rd  out  1  read strobe to the voice store
- voice_addr  out  4  voice index being read
- voice_data  in  NUM_BITS_IN  signed Q2.16 sample, valid RD_LAT cycles after voice_rd
- note_out  out  NUM_BITS_OUT  signed Q6.18 mixed sample, held until the next result
- note_valid  out  1  one-cycle pulse when note_out updates
- busy  out  1  high from tick acceptance through the note_valid cycle
- overrun  out  1  sticky: a tick arrived while busy
- ovr_clr  in  1  clears overrun

Behaviour:
- Reset: all outputs are 0. State is IDLE. The accumulator, counter, enable latch and read-valid pipeline are cleared.
- rst has priority over every other input. A reset during a pass aborts it: no note_valid is issued, note_out returns to 0, and data still in flight is discarded.
- State IDLE: busy=0. If sample_tick=1 in cycle 0, go to RUN. On entry: latch voice_en into en_q, set cnt=0 and acc=0.
- State RUN: cycles 1..16.
  - voice_addr = cnt, counting 0..15.
  - voice_rd = en_q[cnt]. Disabled voices generate no read strobe, but their slot is still consumed, so the schedule is fixed.
  - After cnt=15, go to DRAIN.
- Read-valid pipeline: a RD_LAT-deep shift register carries voice_rd.
  - When its output is 1, acc <= acc + sign_extend(voice_data) at the cycle end.
  - acc is 22-bit Q6.16.
  - No saturation is needed: 16 × Q2.16 cannot overflow Q6.16.
- State DRAIN: wait until the last slot's pipeline stage has retired. This takes RD_LAT cycles after the final RUN cycle.
  - Then note_out <= {acc, 2'b00}, a Q6.16 to Q6.18 conversion by zero-filling the LSBs.
  - note_valid = 1 for exactly one cycle, the cycle in which note_out first shows the new value. Then return to IDLE.
- Latency: tick in cycle 0 gives note_valid in cycle 17+RD_LAT (cycle 18 for the default). Minimum tick spacing is 18+RD_LAT cycles.
- busy is 1 in cycles 1..17+RD_LAT inclusive.
- Tick while busy (including the note_valid cycle): the tick is ignored, the pass in progress is unaffected, and overrun is set.
- A tick in the cycle after note_valid is accepted normally.
- overrun: set has priority over ovr_clr in the same cycle. It is cleared only by ovr_clr or rst.
- voice_en changes during a pass have no effect until the next accepted tick.
- voice_en = 0: no voice_rd at all, but note_valid still fires at the same latency with note_out = 0.
- voice_data is ignored whenever the pipeline output is 0.

Test Plan:
- All enabled, every voice = 0x10000 (+1.0), RD_LAT=1, tick at cycle 0.
  -> voice_rd is high in cycles 1–16 with addr 0–15; note_valid in cycle 18; note_out = 0x400000 (+16.0).
- All enabled, every voice = 0x20000 (−2.0).
  -> note_out = 0x800000 (−32.0), which is the full negative range with no wrap.
- voice_en = 0x0005, voice0 = 0x08000 (+0.5), voice2 = 0x38000 (−0.5), all other voices drive 0x1FFFF.
  -> voice_rd only at addr 0 and 2; note_out = 0x000000; note_valid still in cycle 18.
- Second tick at cycle 10 of a pass, then ovr_clr at cycle 30.
  -> the first result is unchanged; overrun = 1 from cycle 11 to cycle 30; no second pass starts.
- rst asserted in cycle 9 of a pass.
  -> from the next cycle: busy = 0, note_out = 0, no note_valid; a fresh tick afterwards produces a correct result.
- RD_LAT=3, all enabled, voice i = i × 0x00400.
  -> note_valid in cycle 20; note_out = 120 × 0x400 × 4 = 0x01E000 × 4 = 0x078000.

Source files
------------

// File: rtl/voice_mix_sched.sv
// Time-multiplexed 16-voice mixer: one shared accumulator walks the voice store
// once per sample tick and emits a single Q6.18 mixed sample with a valid pulse.
module voice_mix_sched #(
    parameter int NUM_BITS_IN  = 18,
    parameter int NUM_BITS_OUT = 24,
    parameter int RD_LAT       = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic [15:0]             voice_en,
    output logic                    voice_rd,
    output logic [3:0]              voice_addr,
    input  logic [NUM_BITS_IN-1:0]  voice_data,
    output logic [NUM_BITS_OUT-1:0] note_out,
    output logic                    note_valid,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    ovr_clr
);

    localparam int ACC_W = NUM_BITS_OUT - 2;
    localparam logic [3:0] DRAIN_LAST = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Handshake: voice_rd is a fire-and-forget strobe; voice_data is trusted
    // exactly RD_LAT cycles later and only when the read-valid pipe says so.
    state_t              state;
    logic [3:0]          cnt;
    logic [15:0]         en_q;
    logic [RD_LAT-1:0]   rd_pipe;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]    data_ext;
    logic                rd_out;

    assign rd_out   = rd_pipe[RD_LAT-1];
    assign data_ext = {{(ACC_W-NUM_BITS_IN){voice_data[NUM_BITS_IN-1]}}, voice_data};
    assign acc_next = rd_out ? acc + data_ext : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            en_q       <= '0;
            rd_pipe    <= '0;
            acc        <= '0;
            voice_rd   <= 1'b0;
            voice_addr <= '0;
            note_out   <= '0;
            note_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            note_valid <= 1'b0;
            rd_pipe[0] <= voice_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            acc <= acc_next;

            // A set in the same cycle as a clear wins.
            if (sample_tick && busy) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        en_q       <= voice_en;
                        cnt        <= '0;
                        acc        <= '0;
                        voice_addr <= '0;
                        voice_rd   <= voice_en[0];
                    end
                end
                RUN: begin
                    if (cnt == 4'd15) begin
                        state    <= DRAIN;
                        cnt      <= '0;
                        voice_rd <= 1'b0;
                    end else begin
                        cnt        <= cnt + 4'd1;
                        voice_addr <= cnt + 4'd1;
                        voice_rd   <= en_q[cnt + 4'd1];
                    end
                end
                DRAIN: begin
                    // The last slot retires this cycle, so fold it in directly.
                    if (cnt == DRAIN_LAST) begin
                        note_out   <= {acc_next, 2'b00};
                        note_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
